// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch slice.
// Imported by pc_next_sel and pc_fetch_unit.
package pc_fetch_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          PC_INCR      = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    HOLD,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: JALR beats branch, which beats PC+4.
// Also flags targets that are not word aligned.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] instr_pc,
  input  logic [XLEN-1:0] branch_offset,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            branch_take,
  input  logic            jalr_take,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Sums wrap silently modulo 2^XLEN; JALR clears only bit 0, so bit 1 can still fault.
  always_comb begin
    if (jalr_take) begin
      next_pc = {jalr_target[XLEN-1:1], 1'b0};
    end else if (branch_take) begin
      next_pc = instr_pc + branch_offset;
    end else begin
      next_pc = instr_pc + XLEN'(PC_INCR);
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: request/response to imem,
// valid/ready handoff to decode, next-PC update on each handoff.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            jalr_take,
  input  logic [XLEN-1:0] jalr_target,
  output logic            fetch_fault
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            handoff;

  assign handoff = (state == HOLD) && instr_ready;

  pc_next_sel #(.XLEN(XLEN)) u_next_sel (
    .instr_pc      (instr_pc),
    .branch_offset (branch_offset),
    .jalr_target   (jalr_target),
    .branch_take   (branch_take),
    .jalr_take     (jalr_take),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = REQ;
      REQ:      if (imem_req_ready) state_nxt = WAIT_RSP;
      WAIT_RSP: if (imem_rsp_valid) state_nxt = HOLD;
      HOLD:     if (handoff) state_nxt = misaligned ? FAULT : REQ;
      FAULT:    state_nxt = FAULT;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == REQ);
    instr_valid    = (state == HOLD);
    fetch_fault    = (state == FAULT);
  end

  assign imem_req_addr = pc;

  // pc takes the new target even when it faults, so the bad address stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      instr_pc <= RESET_PC;
    end else begin
      if ((state == WAIT_RSP) && imem_rsp_valid) begin
        instr    <= imem_rsp_data;
        instr_pc <= pc;
      end
      if (handoff) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: fetch sequencing, redirects,
// stalls, wrap-around, misalignment fault and asynchronous reset.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        branch_take = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        jalr_take = 1'b0;
  logic [31:0] jalr_target = '0;
  logic        fetch_fault;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .branch_take    (branch_take),
    .branch_offset  (branch_offset),
    .jalr_take      (jalr_take),
    .jalr_target    (jalr_target),
    .fetch_fault    (fetch_fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    checkOutput({tag, "_req_addr"}, imem_req_addr, 32'h0);
    checkOutput({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "_instr"}, instr, 32'h0000_0013);
    checkOutput({tag, "_instr_pc"}, instr_pc, 32'h0);
    checkOutput({tag, "_fault"}, 32'(fetch_fault), 32'd0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a request, optionally stall it, accept it, answer after rspDelay cycles.
  task automatic fetchOne(input logic [31:0] expAddr, input logic [31:0] data,
                          input int reqStall, input int rspDelay);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("req_addr", imem_req_addr, expAddr);
    for (int i = 0; i < reqStall; i++) begin
      @(negedge clk);
      checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("stall_req_addr", imem_req_addr, expAddr);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    checkOutput("wait_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 1; i < rspDelay; i++) begin
      @(negedge clk);
      checkOutput("wait_instr_valid", 32'(instr_valid), 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checkOutput("instr_valid", 32'(instr_valid), 32'd1);
    checkOutput("instr", instr, data);
    checkOutput("instr_pc", instr_pc, expAddr);
  endtask

  // One handoff cycle to decode with the given redirect inputs.
  task automatic applyStimulus(input logic br, input logic [31:0] off,
                               input logic jr, input logic [31:0] tgt);
    instr_ready   = 1'b1;
    branch_take   = br;
    branch_offset = off;
    jalr_take     = jr;
    jalr_target   = tgt;
    @(negedge clk);
    instr_ready = 1'b0;
    branch_take = 1'b0;
    jalr_take   = 1'b0;
    checkOutput("handoff_instr_valid", 32'(instr_valid), 32'd0);
  endtask

  task automatic expectNextReq(input string tag, input logic [31:0] expAddr);
    checkOutput({tag, "_valid"}, 32'(imem_req_valid), 32'd1);
    checkOutput({tag, "_addr"}, imem_req_addr, expAddr);
  endtask

  initial begin
    int reqSeen;

    applyReset();

    fetchOne(32'h0, 32'h0050_0093, 0, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expectNextReq("seq_4", 32'h4);
    fetchOne(32'h4, 32'h0000_0113, 0, 2);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expectNextReq("seq_8", 32'h8);
    fetchOne(32'h8, 32'h0000_0193, 0, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expectNextReq("seq_c", 32'hC);
    fetchOne(32'hC, 32'h0000_0213, 3, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expectNextReq("seq_10", 32'h10);

    fetchOne(32'h10, 32'h0000_0293, 0, 1);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    expectNextReq("branch_back", 32'h8);

    fetchOne(32'h8, 32'h0000_0313, 0, 1);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 32'h101);
    expectNextReq("jalr_prio", 32'h100);

    // Decode stalls in HOLD; stray response and redirect inputs must not disturb anything.
    fetchOne(32'h100, 32'hDEAD_0393, 0, 1);
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0000 + 32'(i);
      branch_take    = 1'b1;
      branch_offset  = 32'h40;
      @(negedge clk);
      checkOutput("hold_instr", instr, 32'hDEAD_0393);
      checkOutput("hold_instr_pc", instr_pc, 32'h100);
      checkOutput("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    imem_rsp_valid = 1'b0;
    branch_take    = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expectNextReq("after_hold", 32'h104);

    fetchOne(32'h104, 32'h0000_0413, 0, 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    expectNextReq("jalr_top", 32'hFFFF_FFFC);
    fetchOne(32'hFFFF_FFFC, 32'h0000_0493, 0, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expectNextReq("wrap", 32'h0);

    // Accept the request, then drop reset mid-cycle while waiting for the response.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async");
    @(negedge clk);
    rst_n = 1'b1;

    fetchOne(32'h0, 32'h0000_0513, 0, 1);
    applyStimulus(1'b1, 32'h6, 1'b0, 32'h0);
    checkOutput("fault_set", 32'(fetch_fault), 32'd1);
    reqSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid) reqSeen++;
    end
    checkOutput("fault_no_req", 32'(reqSeen), 32'd0);
    checkOutput("fault_sticky", 32'(fetch_fault), 32'd1);

    applyReset();
    fetchOne(32'h0, 32'h0000_0593, 0, 1);
    checkOutput("refetch_fault", 32'(fetch_fault), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the program counter and fetches instructions from instruction memory over a valid/ready request and response handshake.
- Hands each fetched instruction, with its PC, to the decode stage through a valid/ready handshake.
- Computes the next PC when decode accepts an instruction: sequential (PC+4), branch target (PC + shifted branch offset), or JALR target.
- Sits directly upstream of decode/execute. It consumes the already-shifted branch offset produced by the immediate shift stage.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  XLEN  fetch address
- imem_req_ready  input  1  memory accepts the request this cycle
- imem_rsp_valid  input  1  response data valid
- imem_rsp_data  input  32  fetched instruction word
- instr_valid  output  1  instruction available to decode
- instr  output  32  instruction word
- instr_pc  output  XLEN  PC of instr
- instr_ready  input  1  decode accepts instr this cycle
- branch_take  input  1  taken branch/JAL; qualified by instr_valid & instr_ready
- branch_offset  input  XLEN  sign-extended immediate, already shifted left by 1
- jalr_take  input  1  JALR redirect; priority over branch_take
- jalr_target  input  XLEN  rs1+imm; bit 0 is cleared by this block
- fetch_fault  output  1  sticky misaligned-target fault

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state IDLE
  - imem_req_valid=0, imem_req_addr=RESET_PC
  - instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC
  - fetch_fault=0, internal pc=RESET_PC
- The memory shares rst_n, so no stale response exists after reset. Reset mid-transaction abandons the transaction.
- State machine:
  - IDLE -> REQ unconditionally on the first edge after reset release.
  - REQ: imem_req_valid=1, imem_req_addr=pc. Address and valid stay stable until imem_req_ready. On valid&ready -> WAIT_RSP.
  - WAIT_RSP: on imem_rsp_valid, register instr=imem_rsp_data and instr_pc=pc, set instr_valid=1 -> HOLD. Response accepted in the same cycle as request acceptance is not allowed (minimum one cycle).
  - HOLD: instr_valid=1 and instr stays stable until instr_ready. On handoff (instr_valid&instr_ready): instr_valid=0, pc=next_pc, -> REQ, or -> FAULT if next_pc[1:0]!=0.
  - FAULT: fetch_fault=1 and sticky; no requests; exit only by reset. pc holds the offending target for debug.
- next_pc, evaluated only at the handoff cycle:
  - jalr_take: {jalr_target[XLEN-1:1],1'b0}
  - else branch_take: instr_pc + branch_offset
  - else instr_pc + 32'd4
- Arithmetic is modulo 2^XLEN; wrap-around is silent (e.g. 32'hFFFF_FFFC + 4 = 0).
- branch_take/jalr_take outside a handoff cycle are ignored. Both high: JALR wins.
- imem_rsp_valid outside WAIT_RSP is ignored.
- Latency:
  - request accepted at cycle t, response at t+k (k>=1) -> instr_valid at t+k+1
  - handoff at cycle h -> next imem_req_valid at h+1
- Throughput: at most one instruction per 3 cycles with zero-wait memory.

Decomposition:
- Shared package pc_fetch_pkg:
  - XLEN_DEFAULT
  - NOP_INSTR (32'h0000_0013)
  - PC_INCR (4)
  - fetch state enum (IDLE, REQ, WAIT_RSP, HOLD, FAULT)
- One combinational sub-module, pc_next_sel: inputs instr_pc, branch_offset, jalr_target, branch_take, jalr_take; outputs next_pc and misaligned. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset release, ready=1, rsp after 1 cycle with data 32'h0050_0093 -> req_addr=0, instr=32'h0050_0093 and instr_pc=0; on handoff with no redirect, next req_addr=4.
- Sequential run of 4 handoffs -> req_addr sequence 0,4,8,C. imem_req_ready held low 3 cycles -> req_addr/valid stable throughout.
- Handoff at instr_pc=32'h10, branch_take=1, branch_offset=32'hFFFF_FFF8 -> next req_addr=32'h08. Same with branch_take=1 and jalr_take=1, jalr_target=32'h101 -> req_addr=32'h100.
- Handoff with branch_take=1, offset=32'h6 at instr_pc=0 -> fetch_fault=1, no further imem_req_valid for 20 cycles. Reset clears the fault and refetches from 0.
- instr_pc=32'hFFFF_FFFC, no redirect -> next req_addr=0. Assert rst_n=0 asynchronously while in WAIT_RSP -> all outputs at reset values immediately, before the next clock edge.
- instr_ready held low 5 cycles in HOLD -> instr and instr_pc unchanged, no new request issued. Spurious imem_rsp_valid during HOLD -> ignored.
